// File: rtl/green_seq.sv
// green_seq: multi-cycle fetch/exec/store sequencer for the green core.
// Ports: CLK/RST, RUN, IMEM req/ack/addr/data, INS, REG_EN, DMEM req/ack,
//        BR_TAKEN/BR_TGT from decoder, PC, HALTED, ILL, BUS_ERR.
module green_seq #(
  parameter logic [15:0] PC_RST      = 16'h0000,
  parameter int          BUS_TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RUN,
  output logic        IMEM_REQ,
  output logic [15:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [15:0] IMEM_DATA,
  output logic [15:0] INS,
  output logic        REG_EN,
  output logic        DMEM_REQ,
  input  logic        DMEM_ACK,
  input  logic        BR_TAKEN,
  input  logic [15:0] BR_TGT,
  output logic [15:0] PC,
  output logic        HALTED,
  output logic        ILL,
  output logic        BUS_ERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_STORE,
    S_HALT
  } state_t;

  localparam logic [7:0] TMO_LIM = 8'(BUS_TIMEOUT);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ins_q, ins_d;
  logic        ireq_q, ireq_d;
  logic        dreq_q, dreq_d;
  logic        reg_en_q, reg_en_d;
  logic        halted_q, halted_d;
  logic        ill_q, ill_d;
  logic        bus_err_q, bus_err_d;
  logic [7:0]  tmo_q, tmo_d;

  logic [3:0]  ex_opc;
  logic [3:0]  fe_opc;
  logic        tmo_hit;
  logic [15:0] pc_inc;

  assign ex_opc  = ins_q[15:12];
  assign fe_opc  = IMEM_DATA[15:12];
  assign pc_inc  = pc_q + 16'd1;
  // This cycle would be the last allowed one without an ack
  assign tmo_hit = (tmo_q + 8'd1) >= TMO_LIM;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ins_d     = ins_q;
    ireq_d    = ireq_q;
    dreq_d    = dreq_q;
    reg_en_d  = 1'b0;
    halted_d  = halted_q;
    ill_d     = ill_q;
    bus_err_d = bus_err_q;
    tmo_d     = tmo_q;

    unique case (state_q)
      S_IDLE: begin
        if (RUN) begin
          state_d = S_FETCH;
          ireq_d  = 1'b1;
          tmo_d   = 8'd0;
        end
      end

      S_FETCH: begin
        if (IMEM_ACK) begin
          ins_d    = IMEM_DATA;
          ireq_d   = 1'b0;
          state_d  = S_EXEC;
          // Strobe is registered, so decide it from the incoming word
          reg_en_d = (fe_opc == 4'h0) || (fe_opc == 4'h2);
        end else if (tmo_hit) begin
          bus_err_d = 1'b1;
          ireq_d    = 1'b0;
          halted_d  = 1'b1;
          state_d   = S_HALT;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      S_EXEC: begin
        unique case (1'b1)
          (ex_opc == 4'h1): begin
            state_d = S_STORE;
            dreq_d  = 1'b1;
            tmo_d   = 8'd0;
          end
          (ex_opc == 4'hF): begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end
          default: begin
            if (ex_opc == 4'h3 && BR_TAKEN) begin
              pc_d = BR_TGT;
            end else begin
              pc_d = pc_inc;
            end
            if (ex_opc > 4'h3) begin
              ill_d = 1'b1;
            end
            if (RUN) begin
              state_d = S_FETCH;
              ireq_d  = 1'b1;
              tmo_d   = 8'd0;
            end else begin
              state_d = S_IDLE;
            end
          end
        endcase
      end

      S_STORE: begin
        if (DMEM_ACK) begin
          dreq_d = 1'b0;
          pc_d   = pc_inc;
          if (RUN) begin
            state_d = S_FETCH;
            ireq_d  = 1'b1;
            tmo_d   = 8'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (tmo_hit) begin
          bus_err_d = 1'b1;
          dreq_d    = 1'b0;
          halted_d  = 1'b1;
          state_d   = S_HALT;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      S_HALT: begin
        halted_d = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      pc_q      <= PC_RST;
      ins_q     <= 16'h0000;
      ireq_q    <= 1'b0;
      dreq_q    <= 1'b0;
      reg_en_q  <= 1'b0;
      halted_q  <= 1'b0;
      ill_q     <= 1'b0;
      bus_err_q <= 1'b0;
      tmo_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ins_q     <= ins_d;
      ireq_q    <= ireq_d;
      dreq_q    <= dreq_d;
      reg_en_q  <= reg_en_d;
      halted_q  <= halted_d;
      ill_q     <= ill_d;
      bus_err_q <= bus_err_d;
      tmo_q     <= tmo_d;
    end
  end

  assign IMEM_REQ  = ireq_q;
  assign IMEM_ADDR = pc_q;
  assign INS       = ins_q;
  assign REG_EN    = reg_en_q;
  assign DMEM_REQ  = dreq_q;
  assign PC        = pc_q;
  assign HALTED    = halted_q;
  assign ILL       = ill_q;
  assign BUS_ERR   = bus_err_q;

endmodule

// File: tb/tb_green_seq.sv
// tb_green_seq: directed bench for green_seq with memory responders,
// a transaction-level reference model and literal spot checks.
module tb_green_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, run;
  logic        imem_req, imem_ack;
  logic [15:0] imem_addr, imem_data, ins;
  logic        reg_en, dmem_req, dmem_ack;
  logic        br_taken;
  logic [15:0] br_tgt, pc;
  logic        halted, ill, bus_err;

  green_seq #(.PC_RST(16'h0000), .BUS_TIMEOUT(15)) dut (
    .CLK(clk), .RST(rst), .RUN(run),
    .IMEM_REQ(imem_req), .IMEM_ADDR(imem_addr),
    .IMEM_ACK(imem_ack), .IMEM_DATA(imem_data),
    .INS(ins), .REG_EN(reg_en),
    .DMEM_REQ(dmem_req), .DMEM_ACK(dmem_ack),
    .BR_TAKEN(br_taken), .BR_TGT(br_tgt),
    .PC(pc), .HALTED(halted), .ILL(ill), .BUS_ERR(bus_err)
  );

  logic [15:0] mem   [0:65535];
  logic        br_tk [0:65535];
  logic [15:0] br_tg [0:65535];

  // Decoder stand-in: branch outcome is a property of the address
  assign br_taken = br_tk[imem_addr];
  assign br_tgt   = br_tg[imem_addr];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory responders: ack after a programmable number of wait cycles
  int imem_wait = 0, dmem_wait = 0;
  bit imem_noack = 0, dmem_noack = 0;
  int icyc = 0, dcyc = 0;

  always @(posedge clk) begin
    #1;
    if (imem_req) icyc++; else icyc = 0;
    if (dmem_req) dcyc++; else dcyc = 0;
    imem_ack  = imem_req && !imem_noack && (icyc > imem_wait);
    imem_data = mem[imem_addr];
    dmem_ack  = dmem_req && !dmem_noack && (dcyc > dmem_wait);
  end

  // Reference model: tracks which phase of an instruction we are in
  localparam int M_IDLE = 0, M_FETCH = 1, M_EXEC = 2;
  localparam int M_STORE = 3, M_HALT = 4;
  int          m_ph;
  int          m_out;
  logic [15:0] m_pc, m_ins;
  bit          m_ireq, m_dreq, m_regen, m_halt, m_ill, m_berr;
  bit          m_ok = 0;

  task automatic m_next_instr(input bit r);
    if (r) begin
      m_ph = M_FETCH; m_ireq = 1; m_out = 0;
    end else begin
      m_ph = M_IDLE;
    end
  endtask

  always @(posedge clk) begin
    int op;
    m_regen = 0;
    if (rst) begin
      m_ph = M_IDLE; m_pc = 16'h0000; m_ins = 16'h0000;
      m_ireq = 0; m_dreq = 0; m_halt = 0; m_ill = 0; m_berr = 0;
      m_out = 0; m_ok = 1;
    end else if (m_ok) begin
      case (m_ph)
        M_IDLE: m_next_instr(run);
        M_FETCH: begin
          if (imem_ack) begin
            m_ins = imem_data; m_ireq = 0; m_ph = M_EXEC;
            op = int'(imem_data[15:12]);
            m_regen = (op == 0 || op == 2);
          end else begin
            m_out++;
            if (m_out >= 15) begin
              m_berr = 1; m_ireq = 0; m_halt = 1; m_ph = M_HALT;
            end
          end
        end
        M_EXEC: begin
          op = int'(m_ins[15:12]);
          if (op == 1) begin
            m_ph = M_STORE; m_dreq = 1; m_out = 0;
          end else if (op == 15) begin
            m_ph = M_HALT; m_halt = 1;
          end else begin
            if (op == 3 && br_taken) m_pc = br_tgt;
            else m_pc = 16'((32'(m_pc) + 1) % 65536);
            if (op >= 4) m_ill = 1;
            m_next_instr(run);
          end
        end
        M_STORE: begin
          if (dmem_ack) begin
            m_dreq = 0;
            m_pc = 16'((32'(m_pc) + 1) % 65536);
            m_next_instr(run);
          end else begin
            m_out++;
            if (m_out >= 15) begin
              m_berr = 1; m_dreq = 0; m_halt = 1; m_ph = M_HALT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("pc", pc, m_pc);
      chk("imem_addr", imem_addr, m_pc);
      chk("imem_req", imem_req, m_ireq);
      chk("dmem_req", dmem_req, m_dreq);
      chk("reg_en", reg_en, m_regen);
      chk("ins", ins, m_ins);
      chk("halted", halted, m_halt);
      chk("ill", ill, m_ill);
      chk("bus_err", bus_err, m_berr);
      chk("req_mutex", imem_req & dmem_req, 0);
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'h0000; br_tk[i] = 1'b0; br_tg[i] = 16'h0000;
    end
  endtask

  task automatic do_reset();
    rst = 1; run = 0;
    repeat (2) @(posedge clk);
    #2 rst = 0;
  endtask

  task automatic start_run();
    run = 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    logic [5:0] rg;
    rst = 1; run = 0;
    imem_ack = 0; dmem_ack = 0; imem_data = 0;
    clear_mem();

    // Reset and idle
    do_reset();
    repeat (10) @(negedge clk);
    chk("idle_pc", pc, 16'h0000);
    chk("idle_req", {imem_req, dmem_req, reg_en}, 0);
    chk("idle_flags", {halted, ill, bus_err}, 0);
    chk("idle_ins", ins, 16'h0000);

    // Straight-line, store, illegal, branches, halt
    mem[0] = 16'h0000; mem[1] = 16'h2000; mem[2] = 16'h0800;
    mem[3] = 16'h1000; mem[4] = 16'h7000; mem[5] = 16'h3000;
    br_tk[5] = 1; br_tg[5] = 16'h0040;
    mem[16'h0040] = 16'h3000;
    mem[16'h0041] = 16'hF000;
    dmem_wait = 3;
    #2 start_run();
    chk("first_fetch", {imem_req, imem_addr}, {1'b1, 16'h0000});
    rg = '0;
    rg[0] = reg_en;
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      rg[i] = reg_en;
      if (i == 1) chk("ins_w0", ins, 16'h0000);
      if (i == 3) chk("ins_w1", ins, 16'h2000);
      if (i == 5) chk("ins_w2", ins, 16'h0800);
    end
    chk("regen_pattern", rg, 6'b101010);
    @(negedge clk);
    chk("pc_after_3", pc, 16'h0003);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (dmem_req) cnt++;
    end
    chk("store_req_cycles", cnt, 4);
    chk("ill_pc5", {ill, pc}, {1'b1, 16'h0005});
    repeat (2) @(negedge clk);
    chk("br_taken_addr", imem_addr, 16'h0040);
    repeat (2) @(negedge clk);
    chk("br_not_taken_addr", imem_addr, 16'h0041);
    repeat (2) @(negedge clk);
    chk("halt_set", halted, 1'b1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req) cnt++;
    end
    chk("halt_no_req", cnt, 0);

    // PC wrap through 16'hFFFF, then halt
    do_reset();
    dmem_wait = 0;
    clear_mem();
    mem[0] = 16'h3000; br_tk[0] = 1; br_tg[0] = 16'hFFFF;
    mem[16'hFFFF] = 16'h7000;
    mem[1] = 16'hF000;
    start_run();
    repeat (2) @(negedge clk);
    chk("fetch_ffff", imem_addr, 16'hFFFF);
    repeat (2) @(negedge clk);
    chk("wrap_0000", {imem_req, imem_addr}, {1'b1, 16'h0000});
    br_tk[0] = 0;
    repeat (4) @(negedge clk);
    chk("wrap_halted", {halted, pc}, {1'b1, 16'h0001});

    // Fetch timeout
    do_reset();
    imem_noack = 1;
    run = 1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req) cnt++;
    end
    chk("tmo_req_cycles", cnt, 15);
    chk("tmo_flags", {bus_err, halted}, 2'b11);
    imem_noack = 0;

    // Ack on the last allowed cycle
    do_reset();
    clear_mem();
    mem[0] = 16'hF000;
    imem_wait = 14;
    run = 1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req) cnt++;
    end
    chk("late_ack_cycles", cnt, 15);
    chk("late_ack_flags", {bus_err, halted}, 2'b01);
    imem_wait = 0;

    // Reset during a store wait
    do_reset();
    mem[0] = 16'h1000;
    dmem_noack = 1;
    start_run();
    repeat (4) @(negedge clk);
    chk("store_pending", dmem_req, 1'b1);
    rst = 1; run = 0;
    @(negedge clk);
    chk("rst_store", {dmem_req, imem_req, halted}, 3'b000);
    rst = 0;
    dmem_noack = 0;
    repeat (2) @(negedge clk);
    chk("rst_store_pc", pc, 16'h0000);

    // RUN pulse: one instruction completes, then idle
    do_reset();
    mem[0] = 16'h2000; mem[1] = 16'h2000;
    imem_wait = 2;
    run = 1;
    @(posedge clk);
    #2 run = 0;
    repeat (20) @(negedge clk);
    chk("run_pulse", {imem_req, halted, pc}, {2'b00, 16'h0001});
    imem_wait = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/green_seq.md
Name: green_seq

Overview:
Multi-cycle instruction sequencer for the green circuit. Owns the program counter, fetches 16-bit instructions over a req/ack instruction-memory port, and presents the latched instruction to the green decoder. It then sequences execution: a one-cycle register-commit enable for load/inc, a data-memory store handshake, and PC update from the decoder's branch result. Also provides halt, illegal-opcode and bus-timeout supervision.

Parameters:
PC_RST, 16'h0000, PC value loaded on reset
BUS_TIMEOUT, 15, max cycles REQ may stay high without ACK before bus error (1..255)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  synchronous active-high reset
RUN  in  1  level; 1 = keep issuing instructions
IMEM_REQ  out  1  instruction fetch request
IMEM_ADDR  out  16  fetch address (= PC)
IMEM_ACK  in  1  fetch complete; IMEM_DATA valid this cycle
IMEM_DATA  in  16  fetched instruction
INS  out  16  latched instruction register, drives decoder ins
REG_EN  out  1  one-cycle commit strobe for RA/RB/ZNC registers
DMEM_REQ  out  1  store request (data-memory write enable)
DMEM_ACK  in  1  store complete
BR_TAKEN  in  1  decoder BR_out (branch taken)
BR_TGT  in  16  branch target address
PC  out  16  current program counter
HALTED  out  1  core stopped
ILL  out  1  sticky: illegal opcode executed
BUS_ERR  out  1  sticky: bus timeout occurred

Behaviour:
- Reset (RST=1 at CLK edge, any state): state IDLE, PC=PC_RST, INS=0, IMEM_REQ=0, DMEM_REQ=0, REG_EN=0, HALTED=0, ILL=0, BUS_ERR=0, timeout count=0. Reset overrides any in-flight handshake; a late ACK is ignored.
- All outputs registered. IMEM_ADDR = PC always.
- States: IDLE, FETCH, EXEC, STORE, HALT.
- IDLE: all strobes 0. RUN=1 -> FETCH next cycle.
- FETCH: IMEM_REQ=1, PC held stable. ACK sampled in every FETCH cycle including the first. On ACK: INS<=IMEM_DATA, IMEM_REQ drops, -> EXEC. ACK while not in FETCH is ignored.
- EXEC (exactly 1 cycle; INS stable; decoder combinational), by OPC=INS[15:12]:
  0000 load / 0010 inc: REG_EN=1 this cycle only; PC<=PC+1.
  0001 store: -> STORE, DMEM_REQ=1 from next cycle; PC unchanged.
  0011 branch: REG_EN=0; PC<=BR_TAKEN ? BR_TGT : PC+1 (BR_TAKEN sampled in EXEC only).
  1111 halt: -> HALT; PC unchanged.
  0100-1110: treated as NOP, ILL<=1 (sticky), PC<=PC+1.
  Non-store, non-halt exit: RUN=1 -> FETCH, RUN=0 -> IDLE.
- STORE: DMEM_REQ=1 until DMEM_ACK; on ACK DMEM_REQ drops, PC<=PC+1, -> FETCH (RUN=1) or IDLE (RUN=0).
- RUN deassert mid-instruction: current instruction completes; no new fetch.
- Timeout: counter cleared on entry to FETCH/STORE, increments each cycle REQ is high without ACK; when it reaches BUS_TIMEOUT with no ACK that cycle: BUS_ERR<=1, REQ drops, -> HALT. ACK in the same cycle as the limit wins (no error).
- HALT: HALTED=1, all strobes 0, RUN ignored; exit only via RST.
- PC arithmetic modulo 2^16: 16'hFFFF+1 = 16'h0000.
- Latency with zero-wait memory: load/inc/branch/NOP = 2 cycles (FETCH, EXEC); store = 3 cycles.
- Invariant: IMEM_REQ and DMEM_REQ never high together; REG_EN only in EXEC.

Test Plan:
- Reset/idle: RST 2 cycles, RUN=0 -> PC=0000, all outputs 0 for 10 cycles; RUN=1 -> IMEM_REQ=1 with IMEM_ADDR=0000 next cycle.
- Straight-line: zero-wait memory with program 0000 0x0000, 0x2000, 0x0800 -> REG_EN pulses on cycles 2, 4, 6 after RUN; PC steps 0,1,2,3; INS matches each word.
- Store with wait: instruction 0x1000, DMEM_ACK after 4 cycles -> DMEM_REQ high exactly 4 cycles, REG_EN=0, then PC=PC+1 and fetch resumes.
- Branch: 0x3000 at PC=0005 with BR_TAKEN=1, BR_TGT=0x0040 -> next IMEM_ADDR=0x0040; repeat with BR_TAKEN=0 -> 0x0006.
- Faults: opcode 0x7000 -> ILL=1, PC+1, execution continues; withhold IMEM_ACK -> BUS_ERR=1 and HALTED=1 after exactly 15 REQ cycles; ACK on cycle 15 -> no error.
- Halt/wrap/reset: PC_RST=FFFF with NOP at FFFF -> next fetch 0000; 0xF000 -> HALTED=1, no further REQ with RUN=1; RST during STORE wait -> IDLE, DMEM_REQ=0 next cycle.
